multicycle_control: RTL and testbench

//   Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through

---
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle instruction controller. Each accepted opcode is walked through
//   FETCH/DECODE/EXEC/MEM/WB. Datapath controls are decoded from the current
//   state and the latched opcode, so they change only on state transitions.
//   The one exception is ctl_brop, which follows the ALU zero flag during EXEC
//   of a BEZ. Memory accesses wait for mem_ack, with a bounded wait.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   instr_valid/opcode opcode offered by the instruction register
//   instr_ready        high in FETCH: an offered opcode is taken this cycle
//   zero               ALU zero flag, used by BEZ in EXEC
//   mem_ack            memory completes the current request (MEM only)
//   ctl_*              datapath / memory controls
//   busy               any state other than FETCH
//   illegal, timeout   sticky error flags, cleared only by rst
//
// state  | meaning
// FETCH  | waiting for an opcode, instr_ready high
// DECODE | classify latched opcode, flag illegal ones
// EXEC   | ALU operand/op select, BEZ resolves here
// MEM    | memory request held until ack or timeout
// WB     | register file write
module multicycle_control #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                ctl_alusrc_a,
  output logic                ctl_alusrc_b,
  output logic [ALUOP_W-1:0]  ctl_aluop,
  output logic                ctl_regdst,
  output logic                ctl_memread,
  output logic                ctl_memwrite,
  output logic                ctl_regwrite,
  output logic                ctl_memtoreg,
  output logic                ctl_brop,
  output logic                busy,
  output logic                illegal,
  output logic                timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_SWI  = 4'hA;
  localparam logic [3:0] OP_BEZ  = 4'hB;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(5'b01110);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(5'b00000);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(5'b00001);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    wait_cnt;

  logic [3:0] op_lo;
  logic       op_hi_nz;
  logic       is_alu_rr;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_swi;
  logic       is_bez;
  logic       is_nop;
  logic       is_mem;
  logic       is_legal;

  // Any set bit above the 4-bit opcode field makes the opcode illegal.
  assign op_lo    = op_q[3:0];
  assign op_hi_nz = |(op_q & ~OPCODE_W'(15));

  assign is_nop    = !op_hi_nz && (op_lo == OP_NOP);
  assign is_addi   = !op_hi_nz && (op_lo == OP_ADDI);
  assign is_lw     = !op_hi_nz && (op_lo == OP_LW);
  assign is_sw     = !op_hi_nz && (op_lo == OP_SW);
  assign is_swi    = !op_hi_nz && (op_lo == OP_SWI);
  assign is_bez    = !op_hi_nz && (op_lo == OP_BEZ);
  assign is_alu_rr = !op_hi_nz && ((op_lo == OP_ADD) || (op_lo == OP_SUB) ||
                                   (op_lo == OP_AND) || (op_lo == OP_OR));
  assign is_mem    = is_lw || is_sw || is_swi;
  assign is_legal  = is_nop || is_addi || is_alu_rr || is_mem || is_bez;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            op_q  <= opcode;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!is_legal) begin
            illegal <= 1'b1;
            state   <= S_FETCH;
          end else if (is_nop) begin
            state <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_bez)      state <= S_FETCH;
          else if (is_mem) state <= S_MEM;
          else             state <= S_WB;
        end
        S_MEM: begin
          // An ack arriving on the expiry cycle still completes the access.
          if (mem_ack) begin
            wait_cnt <= '0;
            state    <= is_lw ? S_WB : S_FETCH;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            wait_cnt <= '0;
            timeout  <= 1'b1;
            state    <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    instr_ready  = (state == S_FETCH);
    busy         = (state != S_FETCH);
    ctl_alusrc_a = 1'b0;
    ctl_alusrc_b = 1'b0;
    ctl_aluop    = '0;
    ctl_regdst   = 1'b0;
    ctl_memread  = 1'b0;
    ctl_memwrite = 1'b0;
    ctl_regwrite = 1'b0;
    ctl_memtoreg = 1'b0;
    ctl_brop     = 1'b0;
    case (state)
      S_EXEC: begin
        if (is_alu_rr) begin
          case (op_lo)
            OP_SUB:  ctl_aluop = ALU_SUB;
            OP_AND:  ctl_aluop = ALU_AND;
            OP_OR:   ctl_aluop = ALU_OR;
            default: ctl_aluop = ALU_ADD;
          endcase
        end else if (is_addi) begin
          ctl_alusrc_b = 1'b1;
          ctl_aluop    = ALU_ADD;
        end else if (is_mem) begin
          ctl_alusrc_a = 1'b1;
          ctl_alusrc_b = !is_sw;
          ctl_aluop    = ALU_ADD;
        end else if (is_bez) begin
          ctl_brop = zero;
        end
      end
      S_MEM: begin
        // Address computation from EXEC stays on the bus while memory works.
        ctl_alusrc_a = 1'b1;
        ctl_alusrc_b = !is_sw;
        ctl_aluop    = ALU_ADD;
        ctl_memread  = is_lw;
        ctl_memwrite = is_sw || is_swi;
      end
      S_WB: begin
        ctl_regwrite = 1'b1;
        ctl_regdst   = is_alu_rr || is_lw;
        ctl_memtoreg = is_lw;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       instr_ready;
  logic       zero;
  logic       mem_ack;
  logic       ctl_alusrc_a, ctl_alusrc_b;
  logic [4:0] ctl_aluop;
  logic       ctl_regdst, ctl_memread, ctl_memwrite, ctl_regwrite, ctl_memtoreg, ctl_brop;
  logic       busy, illegal, timeout;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(5), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .zero(zero), .mem_ack(mem_ack),
    .ctl_alusrc_a(ctl_alusrc_a), .ctl_alusrc_b(ctl_alusrc_b), .ctl_aluop(ctl_aluop),
    .ctl_regdst(ctl_regdst), .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
    .ctl_regwrite(ctl_regwrite), .ctl_memtoreg(ctl_memtoreg), .ctl_brop(ctl_brop),
    .busy(busy), .illegal(illegal), .timeout(timeout)
  );

  typedef struct packed {
    logic       ready, busy, a, b;
    logic [4:0] aluop;
    logic       regdst, memread, memwrite, regwrite, memtoreg, brop;
  } outv_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         ackd;   // MEM cycles without ack before the ack; >= T means never
    int         len;    // cycles from accept until FETCH again
    logic       ill;    // sticky flags expected afterwards
    logic       to;
    string      name;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  outv_t exp_q[$];
  logic  mod_ill, mod_to;
  outv_t fetch_v;

  function automatic outv_t dut_v();
    outv_t v;
    v.ready = instr_ready;  v.busy = busy;  v.a = ctl_alusrc_a;  v.b = ctl_alusrc_b;
    v.aluop = ctl_aluop;    v.regdst = ctl_regdst;  v.memread = ctl_memread;
    v.memwrite = ctl_memwrite;  v.regwrite = ctl_regwrite;  v.memtoreg = ctl_memtoreg;
    v.brop = ctl_brop;
    return v;
  endfunction

  // Reference: the per-cycle output list of one instruction, starting with its accept cycle.
  function automatic void build(input logic [3:0] op, input logic z, input int ackd);
    outv_t v, e, bz;
    int n;
    exp_q.delete();
    bz = '0; bz.busy = 1'b1;
    v = '0; v.ready = 1'b1;
    exp_q.push_back(v);
    exp_q.push_back(bz);
    if (!(op inside {[0:5], [8:11]})) begin mod_ill = 1'b1; return; end
    if (op == 0) return;
    if (op <= 5) begin
      v = bz; v.b = (op == 2);
      case (op)
        3: v.aluop = 5'b01110;
        4: v.aluop = 5'b00000;
        5: v.aluop = 5'b00001;
        default: v.aluop = 5'b00010;
      endcase
      exp_q.push_back(v);
      v = bz; v.regwrite = 1'b1; v.regdst = (op != 2);
      exp_q.push_back(v);
      return;
    end
    if (op == 11) begin v = bz; v.brop = z; exp_q.push_back(v); return; end
    e = bz; e.a = 1'b1; e.b = (op != 9); e.aluop = 5'b00010;
    exp_q.push_back(e);
    n = (ackd < T) ? ackd + 1 : T;
    for (int i = 0; i < n; i++) begin
      v = e; v.memread = (op == 8); v.memwrite = (op != 8);
      exp_q.push_back(v);
    end
    if (ackd >= T) mod_to = 1'b1;
    else if (op == 8) begin
      v = bz; v.regwrite = 1'b1; v.regdst = 1'b1; v.memtoreg = 1'b1;
      exp_q.push_back(v);
    end
  endfunction

  task automatic step(input logic v, input logic [3:0] opc, input logic ack, input logic z,
                      input outv_t ev, input logic eill, input logic eto, input string tag);
    outv_t av;
    @(negedge clk);
    instr_valid = v; opcode = opc; mem_ack = ack; zero = z;
    #1;
    av = dut_v();
    checks++;
    if (av !== ev) begin
      errors++;
      $display("FAIL %s outputs: got %h expected %h", tag, av, ev);
    end
    checks++;
    if ({illegal, timeout} !== {eill, eto}) begin
      errors++;
      $display("FAIL %s flags ill/to: got %b%b expected %b%b", tag, illegal, timeout, eill, eto);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input int ackd, input string tag);
    logic pi, pt, mem_op, ack;
    int n;
    pi = mod_ill; pt = mod_to;
    build(op, z, ackd);
    mem_op = (op inside {8, 9, 10});
    n = (ackd < T) ? ackd + 1 : T;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (mem_op && k >= 3 && k < 3 + n) ack = (k - 3 == ackd);
      else ack = 1'($urandom);
      step(k == 0 ? 1'b1 : 1'($urandom), k == 0 ? op : 4'($urandom), ack,
           k == 2 ? z : 1'($urandom), exp_q[k], pi, pt, tag);
    end
  endtask

  vec_t tbl[17];

  initial begin
    fetch_v = '0; fetch_v.ready = 1'b1;
    tbl[0]  = '{4'h1, 1'b0, 0, 4, 1'b0, 1'b0, "add"};
    tbl[1]  = '{4'h2, 1'b0, 0, 4, 1'b0, 1'b0, "addi"};
    tbl[2]  = '{4'h3, 1'b0, 0, 4, 1'b0, 1'b0, "sub"};
    tbl[3]  = '{4'h4, 1'b0, 0, 4, 1'b0, 1'b0, "and"};
    tbl[4]  = '{4'h5, 1'b0, 0, 4, 1'b0, 1'b0, "or"};
    tbl[5]  = '{4'h0, 1'b0, 0, 2, 1'b0, 1'b0, "nop"};
    tbl[6]  = '{4'h8, 1'b0, 0, 5, 1'b0, 1'b0, "lw_ack0"};
    tbl[7]  = '{4'h8, 1'b0, 3, 8, 1'b0, 1'b0, "lw_ack3"};
    tbl[8]  = '{4'h9, 1'b0, 1, 5, 1'b0, 1'b0, "sw_ack1"};
    tbl[9]  = '{4'hA, 1'b0, 0, 4, 1'b0, 1'b0, "swi_ack0"};
    tbl[10] = '{4'hB, 1'b1, 0, 3, 1'b0, 1'b0, "bez_z1"};
    tbl[11] = '{4'hB, 1'b0, 0, 3, 1'b0, 1'b0, "bez_z0"};
    tbl[12] = '{4'hF, 1'b0, 0, 2, 1'b1, 1'b0, "illegal_f"};
    tbl[13] = '{4'h2, 1'b0, 0, 4, 1'b1, 1'b0, "addi_after_ill"};
    tbl[14] = '{4'h9, 1'b0, 9, 7, 1'b1, 1'b1, "sw_timeout"};
    tbl[15] = '{4'h6, 1'b0, 0, 2, 1'b1, 1'b1, "illegal_6"};
    tbl[16] = '{4'h8, 1'b0, 3, 8, 1'b1, 1'b1, "lw_ack_at_expiry"};

    rst = 1'b1; instr_valid = 1'b0; opcode = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    mod_ill = 1'b0; mod_to = 1'b0;
    step(1'b0, 4'h0, 1'b1, 1'b1, fetch_v, 1'b0, 1'b0, "reset_state");

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].ackd, tbl[i].name);
      checks++;
      if (exp_q.size() != tbl[i].len) begin
        errors++;
        $display("FAIL %s model_len: got %0d expected %0d", tbl[i].name, exp_q.size(), tbl[i].len);
      end
      step(1'b0, 4'h0, 1'b0, 1'b0, fetch_v, tbl[i].ill, tbl[i].to, {tbl[i].name, "_end"});
    end

    // Reset in the middle of a SWI memory wait.
    build(4'hA, 1'b0, 100);
    for (int k = 0; k < 4; k++)
      step(k == 0, 4'hA, 1'b0, 1'b0, exp_q[k], 1'b1, 1'b1, "swi_before_rst");
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, fetch_v, 1'b0, 1'b0, "after_rst_in_mem");
    rst = 1'b0;
    mod_ill = 1'b0; mod_to = 1'b0;
    step(1'b0, 4'h0, 1'b1, 1'b0, fetch_v, 1'b0, 1'b0, "idle_after_rst");

    for (int r = 0; r < 300; r++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++)
        step(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), fetch_v, mod_ill, mod_to, "rand_idle");
      run_instr(4'($urandom), 1'($urandom), $urandom_range(0, T + 1), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
